// File: rtl/xor_demo_pkg.sv
// Shared constants for the switch-parity demo: debounce lengths and MODE encoding.
package xor_demo_pkg;

   localparam int DEBOUNCE_DEFAULT = 500000;  // 10 ms at 50 MHz
   localparam int SIM_DEBOUNCE     = 4;

   localparam logic MODE_LIVE   = 1'b0;
   localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, persistence counter and stable flop.
// rise_o is a one-cycle pulse registered on the same edge that stable_o goes 0->1.
module sw_debounce
   import xor_demo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic stable_o,
   output logic rise_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where the input agrees with stable restarts the count, so glitches shorter
   // than DEBOUNCE_CYCLES never reach stable.
   always_comb begin
      stable_d = stable_q;
      rise_d   = 1'b0;
      cnt_d    = cnt_q + CNT_W'(1);
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         rise_d   = sync2_q & ~stable_q;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/xor_parity_debounce.sv
// Debounced N-switch parity: live XOR of the switches, or toggle-on-rising-edge accumulate.
// Optional PARITY transition counter enabled by defining XOR_EDGE_CNT_EN.
module xor_parity_debounce
   import xor_demo_pkg::*;
#(
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic            MAX10_CLK1_50,
   input  logic            RESET,
   input  logic [N_SW-1:0] SW,
   input  logic            MODE,
   output logic [N_SW-1:0] LEDR,
   output logic            PARITY,
   output logic [7:0]      CHANGE_CNT
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [N_SW-1:0] stable;
   logic [N_SW-1:0] rise;
   logic            mode_s1_q, mode_s2_q;
   logic            parity_q, parity_d;

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      sw_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk_i   (MAX10_CLK1_50),
         .rst_i   (RESET),
         .sw_i    (SW[i]),
         .stable_o(stable[i]),
         .rise_o  (rise[i])
      );
   end

   // XOR-reducing rise makes simultaneous rising edges cancel pairwise.
   always_comb begin
      parity_d = ^stable;
      if (mode_s2_q == MODE_TOGGLE) parity_d = parity_q ^ (^rise);
   end

   always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) begin
         mode_s1_q <= MODE_LIVE;
         mode_s2_q <= MODE_LIVE;
         parity_q  <= 1'b0;
      end else begin
         mode_s1_q <= MODE;
         mode_s2_q <= mode_s1_q;
         parity_q  <= parity_d;
      end
   end

   assign LEDR   = stable;
   assign PARITY = parity_q;

`ifdef XOR_EDGE_CNT_EN
   logic [7:0] chg_cnt_q, chg_cnt_d;

   always_comb chg_cnt_d = chg_cnt_q + 8'(parity_d != parity_q);

   always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) chg_cnt_q <= 8'h00;
      else       chg_cnt_q <= chg_cnt_d;
   end

   assign CHANGE_CNT = chg_cnt_q;
`else
   assign CHANGE_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_xor_parity_debounce.sv
// Bench for xor_parity_debounce: directed plan steps then random switching, checked every
// cycle against a window-based reference model. Define XOR_EDGE_CNT_EN to cover the counter.
module tb_xor_parity_debounce;
   import xor_demo_pkg::*;

   localparam int N = 10;
   localparam int D = SIM_DEBOUNCE;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  sw;
   logic          mode;
   wire  [N-1:0]  ledr;
   wire           par;
   wire  [7:0]    ccnt;

   always #5 clk = ~clk;

   xor_parity_debounce #(.N_SW(N), .DEBOUNCE_CYCLES(D)) dut (
      .MAX10_CLK1_50(clk),
      .RESET        (rst),
      .SW           (sw),
      .MODE         (mode),
      .LEDR         (ledr),
      .PARITY       (par),
      .CHANGE_CNT   (ccnt)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: a switch is accepted once its last D synchronised samples all
   // disagree with the accepted value; sample history is kept newest-first.
   logic [N-1:0] m_stable, m_rise;
   logic         m_par;
   int           m_cnt;
   logic [N-1:0] hist[$];
   logic         mhist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_cnt();
`ifdef XOR_EDGE_CNT_EN
      return m_cnt[7:0];
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_reset();
      m_stable = '0;
      m_rise   = '0;
      m_par    = 1'b0;
      m_cnt    = 0;
      hist.delete();
      mhist.delete();
      for (int k = 0; k < D + 2; k++) begin
         hist.push_back('0);
         mhist.push_back(1'b0);
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] nstable;
      logic         npar;
      bit           all_diff;
      if (rst) begin
         model_reset();
         return;
      end
      hist.push_front(sw);
      void'(hist.pop_back());
      mhist.push_front(mode);
      void'(mhist.pop_back());
      // index 2 = value that has crossed both synchroniser stages by this edge
      if (mhist[2]) npar = m_par ^ (^m_rise);
      else          npar = ^m_stable;
      nstable = m_stable;
      for (int b = 0; b < N; b++) begin
         all_diff = 1'b1;
         for (int k = 2; k < D + 2; k++)
            if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) nstable[b] = ~m_stable[b];
      end
      m_rise   = nstable & ~m_stable;
      m_stable = nstable;
      if (npar != m_par) m_cnt++;
      m_par = npar;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/LEDR"},   32'(ledr), 32'(m_stable));
      chk({tag, "/PARITY"}, 32'(par),  32'(m_par));
      chk({tag, "/CNT"},    32'(ccnt), 32'(exp_cnt()));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int j = 0; j < n; j++) tick(tag);
   endtask

   initial begin
      rst  = 1'b1;
      sw   = '0;
      mode = MODE_LIVE;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset/LEDR", 32'(ledr), 32'h0);
      chk("reset/PARITY", 32'(par), 32'h0);
      chk("reset/CNT", 32'(ccnt), 32'h0);
      rst = 1'b0;

      // 1: reset mid-debounce with all switches high
      sw = '1;
      ticks(5, "t1_pre");
      rst = 1'b1;
      model_reset();
      #1;
      check_all("t1_async");
      @(negedge clk);
      ticks(2, "t1_hold");
      rst = 1'b0;
      ticks(5, "t1_wait");
      chk("t1_ledr_early", 32'(ledr), 32'h0);
      tick("t1_acc");
      chk("t1_ledr", 32'(ledr), 32'h3FF);
      tick("t1_par");
      chk("t1_par_even", 32'(par), 32'h0);

      // 2: live parity latency
      sw = '0;
      ticks(8, "t2_settle");
      sw = 10'h001;
      ticks(5, "t2_wait");
      chk("t2_ledr_early", 32'(ledr), 32'h0);
      tick("t2_acc");
      chk("t2_ledr", 32'(ledr), 32'h001);
      chk("t2_par_early", 32'(par), 32'h0);
      tick("t2_par");
      chk("t2_par", 32'(par), 32'h1);
      sw = 10'h003;
      ticks(6, "t2_wait2");
      chk("t2_par2_early", 32'(par), 32'h1);
      tick("t2_par2");
      chk("t2_par2", 32'(par), 32'h0);

      // 3: glitch rejection then acceptance
      sw = '0;
      ticks(8, "t3_settle");
      sw = 10'h004;
      ticks(3, "t3_glitch");
      sw = '0;
      ticks(10, "t3_after");
      chk("t3_rejected", 32'(ledr), 32'h0);
      chk("t3_par_kept", 32'(par), 32'h0);
      sw = 10'h004;
      ticks(5, "t3_long");
      sw = '0;
      tick("t3_acc");
      chk("t3_accepted", 32'(ledr[2]), 32'h1);
      ticks(10, "t3_back");

      // 4: toggle-accumulate
      mode = MODE_TOGGLE;
      ticks(4, "t4_mode");
      sw = 10'h001;
      ticks(7, "t4_r0");
      chk("t4_rise0", 32'(par), 32'h1);
      sw = 10'h000;
      ticks(8, "t4_f0");
      chk("t4_fall0", 32'(par), 32'h1);
      sw = 10'h002;
      ticks(7, "t4_r1");
      chk("t4_rise1", 32'(par), 32'h0);
      sw = 10'h01A;
      ticks(8, "t4_r34");
      chk("t4_rise34", 32'(par), 32'h0);

      // 5: leave toggle mode with PARITY=1 and all switches low
      sw = 10'h03A;
      ticks(7, "t5_r5");
      chk("t5_par_set", 32'(par), 32'h1);
      sw = '0;
      ticks(8, "t5_fall");
      chk("t5_ledr0", 32'(ledr), 32'h0);
      chk("t5_par_hold", 32'(par), 32'h1);
      mode = MODE_LIVE;
      ticks(2, "t5_sync");
      chk("t5_par_sync", 32'(par), 32'h1);
      tick("t5_reload");
      chk("t5_reload", 32'(par), 32'h0);

      // 6: 256 PARITY transitions from a fresh reset
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) begin
         sw[0] = ~sw[0];
         ticks(7, "t6_tog");
         if (i == 254) chk("t6_cnt255", 32'(ccnt), 32'(exp_cnt()));
      end
`ifdef XOR_EDGE_CNT_EN
      chk("t6_wrap", 32'(ccnt), 32'h0);
`else
      chk("t6_tied", 32'(ccnt), 32'h0);
`endif

      // random switching and mode changes
      for (int r = 0; r < 80; r++) begin
         if ($urandom_range(0, 2) == 0) sw = 10'($urandom);
         else                           sw[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         ticks($urandom_range(1, 9), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
